// File: rtl/pi_alu_seq.sv
// pi_alu_seq: sequential signed add/sub/accumulate ALU; iterative shift-add multiplier when PI_ALU_MULT_EN is defined.
// Latency 2 cycles (mul DW+1); start is accepted only in idle and ignored while busy or done.
module pi_alu_seq #(
    parameter int DW   = 16,
    parameter int SATW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    scale,
    input  logic          sat_en,
    input  logic          acc_clr,
    input  logic [DW-1:0] src0,
    input  logic [DW-1:0] src1,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] dst,
    output logic          ovf
);
    localparam int EW = DW + 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (SATW - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ARITH, S_MUL, S_DONE} state_t;

    function automatic logic [DW-1:0] scale_op(input logic [DW-1:0] v, input logic [1:0] sc);
        case (sc)
            2'b01:   scale_op = {v[DW-2:0], 1'b0};
            2'b10:   scale_op = {v[DW-3:0], 2'b00};
            default: scale_op = v;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic          sat_q;
    logic [DW-1:0] s0_q, s1_q;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] dst_q, dst_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] s0_in;
    logic          accept;

    logic signed [EW-1:0] s0_x, s1_x, acc_x, sum_x;
    logic [DW-1:0]        ar_dst;
    logic                 ar_ovf;

    assign s0_in  = scale_op(src0, scale);
    assign accept = (state_q == S_IDLE) && start;
    assign busy   = (state_q == S_ARITH) || (state_q == S_MUL);
    assign done   = (state_q == S_DONE);
    assign dst    = dst_q;
    assign ovf    = ovf_q;

    // Add/sub/accumulate evaluated two bits wider than the data so the clamp sees the true sum.
    always_comb begin
        s0_x  = {{2{s0_q[DW-1]}}, s0_q};
        s1_x  = {{2{s1_q[DW-1]}}, s1_q};
        acc_x = {{2{acc_q[DW-1]}}, acc_q};
        case (op_q)
            OP_ADD:  sum_x = s1_x + s0_x;
            OP_SUB:  sum_x = s1_x + ~s0_x + EW'(1);
            OP_ACC:  sum_x = acc_x + s0_x;
            default: sum_x = '0;
        endcase
        ar_dst = sum_x[DW-1:0];
        ar_ovf = 1'b0;
        if (op_q == OP_MUL) begin
            ar_dst = '0;
            ar_ovf = 1'b1;
        end else if (sat_q && (sum_x < SAT_MIN)) begin
            ar_dst = SAT_MIN[DW-1:0];
            ar_ovf = 1'b1;
        end else if (sat_q && (sum_x > SAT_MAX)) begin
            ar_dst = SAT_MAX[DW-1:0];
            ar_ovf = 1'b1;
        end
    end

`ifdef PI_ALU_MULT_EN
    localparam int PW = 2 * DW - 2;
    localparam int CW = $clog2(DW);

    logic [PW-1:0] mca_q, prod_q, prod_step;
    logic [DW-2:0] mpl_q;
    logic [CW-1:0] cnt_q;
    logic          mul_last;
    logic [DW-1:0] mul_dst;
    logic          mul_ovf;

    // The multiplier sign bit carries negative weight, so its partial product is subtracted.
    always_comb begin
        prod_step = prod_q;
        if (mpl_q[0]) begin
            prod_step = (cnt_q == CW'(DW - 2)) ? (prod_q - mca_q) : (prod_q + mca_q);
        end
        mul_last = (cnt_q == CW'(DW - 1));
        mul_dst  = prod_q[PW-3:DW-4];
        mul_ovf  = 1'b0;
        if (prod_q[PW-1] && (prod_q[PW-2:PW-4] != 3'b111)) begin
            mul_dst = {2'b11, {(DW-2){1'b0}}};
            mul_ovf = 1'b1;
        end else if (!prod_q[PW-1] && (prod_q[PW-2:PW-4] != 3'b000)) begin
            mul_dst = {2'b00, {(DW-2){1'b1}}};
            mul_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mca_q  <= '0;
            mpl_q  <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (accept && (op == OP_MUL)) begin
            mca_q  <= {{(DW-1){s0_in[DW-2]}}, s0_in[DW-2:0]};
            mpl_q  <= src1[DW-2:0];
            prod_q <= '0;
            cnt_q  <= '0;
        end else if ((state_q == S_MUL) && !mul_last) begin
            prod_q <= prod_step;
            mca_q  <= mca_q << 1;
            mpl_q  <= mpl_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef PI_ALU_MULT_EN
                    state_d = (op == OP_MUL) ? S_MUL : S_ARITH;
`else
                    state_d = S_ARITH;
`endif
                end
            end
            S_ARITH: begin
                state_d = S_DONE;
                dst_d   = ar_dst;
                ovf_d   = ar_ovf;
                if (op_q == OP_ACC) acc_d = ar_dst;
            end
            S_MUL: begin
`ifdef PI_ALU_MULT_EN
                if (mul_last) begin
                    state_d = S_DONE;
                    dst_d   = mul_dst;
                    ovf_d   = mul_ovf;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: state_d = S_IDLE;
        endcase
        // A clear wins over everything, including an accumulate finishing this cycle.
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sat_q   <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            acc_q   <= '0;
            dst_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dst_q   <= dst_d;
            ovf_q   <= ovf_d;
            if (accept) begin
                op_q  <= op;
                sat_q <= sat_en;
                s0_q  <= s0_in;
                s1_q  <= src1;
            end
        end
    end

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
    a_dst_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == S_IDLE) || (state_q == S_DONE)) |=> $stable(dst_q));

endmodule

// File: tb/tb_pi_alu_seq.sv
// Self-checking bench for pi_alu_seq: directed table, reset/abort sequence, randomized ops vs. a behavioural model.
module tb_pi_alu_seq;
    localparam int DW   = 16;
    localparam int SATW = 12;

    typedef struct {
        logic [1:0]    op;
        logic [1:0]    scale;
        logic          sat;
        logic          clr;
        logic          hammer;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] dst;
        logic          ovf;
    } vec_t;

    logic          clk, rst_n, start, sat_en, acc_clr;
    logic [1:0]    op, scale;
    logic [DW-1:0] src0, src1;
    logic          busy, done, ovf;
    logic [DW-1:0] dst;

    int            n_checks = 0;
    int            n_errors = 0;
    int            m_acc    = 0;
    logic [DW-1:0] m_dst    = '0;
    vec_t          tbl[$];

    pi_alu_seq #(.DW(DW), .SATW(SATW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .scale(scale),
        .sat_en(sat_en), .acc_clr(acc_clr), .src0(src0), .src1(src1),
        .busy(busy), .done(done), .dst(dst), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] o, input logic [1:0] sc, input logic s,
                                 input logic c, input logic hm, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [DW-1:0] d, input logic ov);
        vec_t v;
        v.op = o; v.scale = sc; v.sat = s; v.clr = c; v.hammer = hm;
        v.a = a; v.b = b; v.dst = d; v.ovf = ov;
        tbl.push_back(v);
    endfunction

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [1:0] o, input logic [1:0] sc, input logic s,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b, input int acc,
                                  output logic [DW-1:0] d, output logic ov);
        logic [DW-1:0] t;
        int            s0, r, lo, hi;
        longint        pa, pb, p, lim;
        t  = a << ((sc == 2'd1) ? 1 : (sc == 2'd2) ? 2 : 0);
        s0 = int'($signed(t));
        lo = -(1 << (SATW - 1));
        hi = (1 << (SATW - 1)) - 1;
        d  = '0;
        ov = 1'b0;
        if (o == 2'b10) begin
`ifdef PI_ALU_MULT_EN
            pa  = longint'($signed(t[DW-2:0]));
            pb  = longint'($signed(b[DW-2:0]));
            p   = pa * pb;
            lim = longint'(1) << (2 * DW - 6);
            if (p < -lim) begin
                d  = DW'(-(1 << (DW - 2)));
                ov = 1'b1;
            end else if (p >= lim) begin
                d  = DW'((1 << (DW - 2)) - 1);
                ov = 1'b1;
            end else begin
                d = DW'(p >>> (DW - 4));
            end
`else
            pa = 0; pb = 0; p = 0; lim = 0;
            d  = '0;
            ov = 1'b1;
`endif
        end else begin
            case (o)
                2'b00:   r = int'($signed(b)) + s0;
                2'b01:   r = int'($signed(b)) - s0;
                default: r = acc + s0;
            endcase
            if (s && (r < lo)) begin
                d  = DW'(lo);
                ov = 1'b1;
            end else if (s && (r > hi)) begin
                d  = DW'(hi);
                ov = 1'b1;
            end else begin
                d = DW'(r);
            end
        end
    endfunction

    task automatic scramble();
        op     = 2'($urandom);
        scale  = 2'($urandom);
        sat_en = 1'($urandom);
        src0   = DW'($urandom);
        src1   = DW'($urandom);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] sc, input logic s, input logic c,
                          input logic hm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] d, output logic ov, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; scale = sc; sat_en = s; acc_clr = c; src0 = a; src1 = b;
        @(posedge clk);
        #1;
        check("busy after start", 32'(busy), 32'd1);
        check("dst held before done", 32'(dst), 32'(m_dst));
        acc_clr = 1'b0;
        start   = hm;
        scramble();
        lat = 0;
        for (int k = 1; k <= DW + 8; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                break;
            end
            scramble();
        end
        d     = dst;
        ov    = ovf;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done single cycle", 32'(done), 32'd0);
        check("idle after done", 32'(busy), 32'd0);
    endtask

    task automatic exec(input string tag, input logic [1:0] o, input logic [1:0] sc, input logic s,
                        input logic c, input logic hm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ed, input logic eo);
        logic [DW-1:0] d;
        logic          ov;
        int            lat, el;
        el = 2;
`ifdef PI_ALU_MULT_EN
        if (o == 2'b10) el = DW + 1;
`endif
        run_op(o, sc, s, c, hm, a, b, d, ov, lat);
        check({tag, " dst"}, 32'(d), 32'(ed));
        check({tag, " ovf"}, 32'(ov), 32'(eo));
        check({tag, " latency"}, lat, el);
        m_dst = ed;
        if (c) m_acc = 0;
        if (o == 2'b11) m_acc = int'($signed(ed));
    endtask

    task automatic exec_model(input string tag, input logic [1:0] o, input logic [1:0] sc, input logic s,
                              input logic c, input logic hm, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] ed;
        logic          eo;
        model(o, sc, s, a, b, c ? 0 : m_acc, ed, eo);
        exec(tag, o, sc, s, c, hm, a, b, ed, eo);
    endtask

    initial begin
        int            dcount;
        logic [1:0]    ro, rsc;
        logic          rs, rc, rhm;
        logic [DW-1:0] ra, rb;

        //    op     scale  sat   clr   hammer src0      src1      dst       ovf
        push(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0100, 16'h0180, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0900, 16'h0000, 16'hF800, 1'b1);
        push(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0900, 16'h0000, 16'hF700, 1'b0);
        push(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0700, 16'h07FF, 1'b1);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h7FFF, 16'h8000, 1'b0);
        push(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0001, 16'h0006, 1'b0);
        push(2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 16'h4001, 16'h0000, 16'h0004, 1'b0);
        push(2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h1234, 16'h0600, 1'b0);
        push(2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h07FF, 1'b1);
        push(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h07FF, 1'b1);
`ifdef PI_ALU_MULT_EN
        push(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0800, 16'h0800, 16'h0400, 1'b0);
        push(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h4000, 16'h3FFF, 1'b1);
        push(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0010, 16'hFFFF, 1'b0);
        push(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0800, 16'hE000, 1'b0);
        push(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h3FFF, 16'hC000, 1'b1);
`else
        push(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0800, 16'h0800, 16'h0000, 1'b1);
`endif

        rst_n = 1'b0; start = 1'b0; op = '0; scale = '0; sat_en = 1'b0; acc_clr = 1'b0;
        src0 = '0; src1 = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dst", 32'(dst), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            exec($sformatf("vec%0d", i), tbl[i].op, tbl[i].scale, tbl[i].sat, tbl[i].clr,
                 tbl[i].hammer, tbl[i].a, tbl[i].b, tbl[i].dst, tbl[i].ovf);
        end

        // Abort an operation in flight with reset; nothing may complete and all state clears.
        dcount = 0;
        @(negedge clk);
`ifdef PI_ALU_MULT_EN
        start = 1'b1; op = 2'b10; src0 = 16'h1234; src1 = 16'h0456; sat_en = 1'b0; scale = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`else
        start = 1'b1; op = 2'b00; src0 = 16'h1234; src1 = 16'h0456; sat_en = 1'b0; scale = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort dst", 32'(dst), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DW + 4) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort no done", dcount, 0);
        m_acc = 0;
        m_dst = '0;
        exec_model("acc after reset", 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        exec_model("add after reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0004);

        for (int i = 0; i < 150; i++) begin
            ro  = 2'($urandom);
            rsc = 2'($urandom);
            rs  = 1'($urandom);
            rc  = ($urandom_range(0, 7) == 0);
            rhm = 1'($urandom);
            ra  = DW'($urandom);
            rb  = DW'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                ra = DW'($signed(10'($urandom)));
                rb = DW'($signed(10'($urandom)));
            end
            exec_model($sformatf("rand%0d", i), ro, rsc, rs, rc, rhm, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
